// File: rtl/sa_stream_pkg.sv
// Shared constants and types for the systolic-array stream wrapper.
package sa_stream_pkg;

  // Geometry of one beat: N A-row elements followed by M B-column elements.
  localparam int ARITH_IN_WIDTH = 64;
  localparam int N              = 8;
  localparam int M              = 7;

  // Flag positions, counted down from the MSB of the data bus.
  localparam int EOB_BIT = 0;
  localparam int SOB_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } framer_state_t;

  // Number of payload bits carried by one beat.
  function automatic int sa_payload_w();
    return (M + N) * ARITH_IN_WIDTH;
  endfunction

endpackage

// File: rtl/sa_skid_buf.sv
// Two-entry skid buffer. head_q drives the output; spare_q catches the beat
// that arrives while the head is stalled. push_ready is registered and means
// "a slot is still free after this cycle", so the producer never sees a
// combinational path from pop_ready.
module sa_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [1:0]       count;
  logic [1:0]       count_n;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] spare_q;
  logic             push_fire;
  logic             pop_fire;

  assign pop_valid = (count != 2'd0);
  assign pop_data  = head_q;
  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    case (count)
      2'd0:    if (push_fire) count_n = 2'd1;
      2'd1: begin
        if (push_fire && !pop_fire)      count_n = 2'd2;
        else if (!push_fire && pop_fire) count_n = 2'd0;
      end
      2'd2:    if (pop_fire) count_n = 2'd1;
      default: count_n = 2'd0;
    endcase
  end

  // Storage, occupancy and registered ready; reset drops any buffered beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_q     <= '0;
      spare_q    <= '0;
      push_ready <= 1'b0;
    end else begin
      count      <= count_n;
      push_ready <= (count_n != 2'd2);
      case (count)
        2'd0: if (push_fire) head_q <= push_data;
        2'd1: begin
          if (push_fire && pop_fire) head_q  <= push_data;
          else if (push_fire)        spare_q <= push_data;
        end
        2'd2: if (pop_fire) head_q <= spare_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sa_block_framer.sv
// Frames the raw DMA read stream into K-beat SA blocks: stamps SOB on the
// first beat and EOB on the last beat of each block, zeroes the pad bits,
// and forwards the beat through a two-entry skid buffer.
//
// Handshake: a beat moves on an interface in a cycle where its valid
// (rts_*) and ready (rtr_*) are both high at the clock edge; valid never
// waits for ready, and once valid is raised the beat and its data hold
// until that edge.
module sa_block_framer
  import sa_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int K_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [K_WIDTH-1:0]    k_depth_i,
  input  logic                  rts_i,
  output logic                  rtr_o,
  input  logic                  sow_i,
  input  logic                  eow_dma_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rts_o,
  input  logic                  rtr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [31:0]           blk_cnt_o,
  output logic                  proto_err_o,
  output logic                  dbg_state
);

  localparam int                 PAYLOAD_W = sa_payload_w();
  localparam logic [K_WIDTH-1:0] K_ONE     = K_WIDTH'(1);

  framer_state_t         state;
  framer_state_t         state_n;
  logic [K_WIDTH-1:0]    beat_cnt;
  logic [K_WIDTH-1:0]    beat_cnt_n;
  logic [K_WIDTH-1:0]    cur_cnt;
  logic [K_WIDTH-1:0]    k_q;
  logic [K_WIDTH-1:0]    k_n;
  logic [K_WIDTH-1:0]    k_eff;
  logic                  err_q;
  logic                  err_n;
  logic                  sob;
  logic                  eob;
  logic                  accept;
  logic [DATA_WIDTH-1:0] framed;
  logic                  unused_pad;

  // Pad bits of the input beat are overwritten, never forwarded.
  assign unused_pad = ^data_i[DATA_WIDTH-1:PAYLOAD_W];

  assign accept      = rts_i & rtr_o;
  assign proto_err_o = err_q;
  assign dbg_state   = state;

  // Block framing: decide SOB/EOB for the accepted beat and advance the FSM.
  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    k_n        = k_q;
    err_n      = err_q;
    sob        = 1'b0;
    eob        = 1'b0;
    cur_cnt    = beat_cnt;
    k_eff      = (k_depth_i == '0) ? K_ONE : k_depth_i;
    if (accept) begin
      case (state)
        IDLE: begin
          // First beat of a stream always opens a block, sow or not.
          k_n = k_eff;
          if ((k_depth_i == '0) || !sow_i) err_n = 1'b1;
          sob        = 1'b1;
          eob        = (k_eff == K_ONE) | eow_dma_i;
          beat_cnt_n = eob ? '0 : K_ONE;
        end
        RUN: begin
          // A sow mid-block abandons the open block and restarts counting.
          if (sow_i) begin
            cur_cnt = '0;
            if (beat_cnt != '0) err_n = 1'b1;
          end
          sob        = (cur_cnt == '0);
          eob        = (cur_cnt == (k_q - K_ONE)) | eow_dma_i;
          beat_cnt_n = eob ? '0 : (cur_cnt + K_ONE);
        end
        default: ;
      endcase
      state_n = eow_dma_i ? IDLE : RUN;
    end
  end

  // Build the outgoing beat: payload, zero pad, then the two flags on top.
  always_comb begin
    framed                          = '0;
    framed[PAYLOAD_W-1:0]           = data_i[PAYLOAD_W-1:0];
    framed[DATA_WIDTH-1-EOB_BIT]    = eob;
    framed[DATA_WIDTH-1-SOB_BIT]    = sob;
  end

  // Framer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      k_q      <= k_n;
      err_q    <= err_n;
    end
  end

  // Count blocks as their EOB beat leaves downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt_o <= 32'd0;
    end else if (rts_o && rtr_i && data_o[DATA_WIDTH-1-EOB_BIT]) begin
      blk_cnt_o <= blk_cnt_o + 32'd1;
    end
  end

  sa_skid_buf #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rts_i),
    .push_ready (rtr_o),
    .push_data  (framed),
    .pop_valid  (rts_o),
    .pop_ready  (rtr_i),
    .pop_data   (data_o)
  );

endmodule

// File: tb/tb_sa_block_framer.sv
// Bench for sa_block_framer: table vectors for the directed block cases,
// a reference model for randomized streams, and a scoreboard on data_o.
module tb_sa_block_framer;
  import sa_stream_pkg::*;

  localparam int DW = 1024;
  localparam int KW = 16;
  localparam int PW = sa_payload_w();

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] k_depth_i = '0;
  logic          rts_i = 1'b0;
  logic          rtr_o;
  logic          sow_i = 1'b0;
  logic          eow_dma_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          rts_o;
  logic          rtr_i = 1'b0;
  logic [DW-1:0] data_o;
  logic [31:0]   blk_cnt_o;
  logic          proto_err_o;
  logic          dbg_state;

  sa_block_framer #(.DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .k_depth_i   (k_depth_i),
    .rts_i       (rts_i),
    .rtr_o       (rtr_o),
    .sow_i       (sow_i),
    .eow_dma_i   (eow_dma_i),
    .data_i      (data_i),
    .rts_o       (rts_o),
    .rtr_i       (rtr_i),
    .data_o      (data_o),
    .blk_cnt_o   (blk_cnt_o),
    .proto_err_o (proto_err_o),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Downstream ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random, 3 = held 0.
  int rtr_mode = 0;
  int rtr_ph = 0;
  always @(posedge clk) begin
    #1;
    case (rtr_mode)
      0: rtr_i = 1'b1;
      1: begin
        rtr_i = ((rtr_ph % 4) == 0) || ((rtr_ph % 4) == 3);
        rtr_ph++;
      end
      2: rtr_i = 1'($urandom_range(0, 1));
      default: rtr_i = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  int            n_total = 0;
  int            n_bad = 0;
  int            exp_blk = 0;
  int            n_retry = 0;
  bit            lat_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act_flags=%b exp_flags=%b act_pad_or=%b act_lo=%h exp_lo=%h",
               name, act[DW-1:DW-2], exp[DW-1:DW-2], |act[DW-3:PW], act[63:0], exp[63:0]);
    end
  endtask

  // Output monitor: handoffs against the expected queue, stall stability,
  // and ready/valid against the bench's own occupancy count.
  int            occ = 0;
  bit            prev_rst = 1;
  bit            held = 0;
  logic [DW-1:0] held_data;
  logic [DW-1:0] mon_exp;
  int            mon_acc;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ      = 0;
      held     = 0;
      prev_rst = 1;
    end else begin
      if (!prev_rst) begin
        chk("rtr_o_free_slot", 64'(rtr_o), 64'(occ < 2));
        chk("rts_o_occupied", 64'(rts_o), 64'(occ != 0));
      end
      prev_rst = 0;
      if (held) begin
        chk("stall_rts_o", 64'(rts_o), 64'd1);
        chk_data("stall_data_o", data_o, held_data);
      end
      if (rts_o && rtr_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_beat act_lo=%h exp=none", data_o[63:0]);
        end else begin
          mon_exp = exp_q.pop_front();
          chk_data("beat", data_o, mon_exp);
          if (mon_exp[DW-1]) exp_blk++;
        end
        if (lat_chk && acc_cyc_q.size() > 0) begin
          mon_acc = acc_cyc_q.pop_front();
          chk("latency", 64'(cyc - mon_acc), 64'd1);
        end
      end
      occ  = occ + int'(rts_i && rtr_o) - int'(rts_o && rtr_i);
      held = rts_o && !rtr_i;
      held_data = data_o;
    end
  end

  // ---------------- reference model ----------------
  // Tracks position inside the current block; a stream starts on the first
  // beat after reset or after an eow beat.
  bit m_in_stream = 0;
  int m_pos = 0;
  int m_k = 1;
  bit m_err = 0;

  task automatic model_step(input bit sow, input bit eow, input int kd,
                            output bit sob, output bit eob);
    if (!m_in_stream) begin
      m_k = (kd == 0) ? 1 : kd;
      if (kd == 0 || !sow) m_err = 1;
      m_pos = 0;
    end else if (sow) begin
      if (m_pos != 0) m_err = 1;
      m_pos = 0;
    end
    sob = (m_pos == 0);
    eob = eow || (m_pos == m_k - 1);
    m_pos = eob ? 0 : m_pos + 1;
    m_in_stream = !eow;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input bit sow, input bit eow, input int kd,
                      input bit use_tbl, input bit tsob, input bit teob);
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    bit sob;
    bit eob;
    int waitc;
    bit done;
    waitc = 0;
    done  = 0;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    sow_i = sow;
    eow_dma_i = eow;
    k_depth_i = kd[KW-1:0];
    data_i = d;
    rts_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rtr_o && rst_n) begin
        if (use_tbl) begin
          sob = tsob;
          eob = teob;
        end else begin
          model_step(sow, eow, kd, sob, eob);
        end
        e = '0;
        e[PW-1:0] = d[PW-1:0];
        e[DW-1] = eob;
        e[DW-2] = sob;
        exp_q.push_back(e);
        if (lat_chk) acc_cyc_q.push_back(cyc);
        done = 1;
      end else begin
        n_retry++;
        waitc++;
        if (waitc > 200) begin
          n_total++;
          n_bad++;
          $display("FAIL accept_timeout act=rtr_o_low exp=accept");
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    rts_i = 1'b0;
  endtask

  task automatic idle(input int n);
    rts_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_in_stream = 0;
    m_pos = 0;
    m_k = 1;
    m_err = 0;
    exp_q.delete();
    acc_cyc_q.delete();
    exp_blk = 0;
  endtask

  task automatic do_reset();
    rts_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    rtr_mode = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout act=%0d exp=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit sow;
    bit eow;
    int kd;
    bit sob;
    bit eob;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sow, input bit eow, input int kd,
                              input bit sob, input bit eob);
    vec_t v;
    v.sow = sow; v.eow = eow; v.kd = kd; v.sob = sob; v.eob = eob;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      send(tbl[i].sow, tbl[i].eow, tbl[i].kd, 1'b1, tbl[i].sob, tbl[i].eob);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit rs;
    bit re;
    // K=4, 12 beats: SOB 0/4/8, EOB 3/7/11.            [0,12)
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(i == 0, i == 11, 4, (i % 4) == 0, (i % 4) == 3));
    // K=4, 6 beats, eow on beat 5: SOB 0/4, EOB 3/5.   [12,18)
    tbl.push_back(mk(1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 4, 0, 1));
    // K=4, sow again on beat 2: SOB 0/2, next EOB on 5. [18,24)
    tbl.push_back(mk(1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1));
    // k_depth=0, 3 beats, eow on last: every beat SOB=EOB. [24,27)
    tbl.push_back(mk(1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1));

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rtr_o", 64'(rtr_o), 64'd0);
    chk("rst_rts_o", 64'(rts_o), 64'd0);
    chk_data("rst_data_o", data_o, '0);
    chk("rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
    chk("rst_proto_err", 64'(proto_err_o), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    chk("rtr_after_rst", 64'(rtr_o), 64'd1);

    // Test 1: full blocks, sustained rate, one-cycle latency.
    do_reset();
    lat_chk = 1;
    n_retry = 0;
    run_vecs(0, 12);
    drain();
    lat_chk = 0;
    chk("t1_no_stall", 64'(n_retry), 64'd0);
    chk("t1_blk_cnt", 64'(blk_cnt_o), 64'd3);
    chk("t1_proto_err", 64'(proto_err_o), 64'd0);
    chk("t1_state", 64'(dbg_state), 64'(IDLE));
    chk("t1_lat_left", 64'(acc_cyc_q.size()), 64'd0);

    // Test 2: partial final block.
    do_reset();
    run_vecs(12, 18);
    drain();
    chk("t2_blk_cnt", 64'(blk_cnt_o), 64'd2);
    chk("t2_proto_err", 64'(proto_err_o), 64'd0);
    chk("t2_state", 64'(dbg_state), 64'(IDLE));

    // Test 4: sow mid-block.
    do_reset();
    run_vecs(18, 24);
    drain();
    chk("t4_proto_err", 64'(proto_err_o), 64'd1);
    chk("t4_blk_cnt", 64'(blk_cnt_o), 64'd1);
    chk("t4_state", 64'(dbg_state), 64'(RUN));

    // Test 5: zero depth.
    do_reset();
    run_vecs(24, 27);
    drain();
    chk("t5_proto_err", 64'(proto_err_o), 64'd1);
    chk("t5_blk_cnt", 64'(blk_cnt_o), 64'd3);
    chk("t5_state", 64'(dbg_state), 64'(IDLE));

    // Test 3: K=8 with downstream ready toggling 1,0,0,1.
    do_reset();
    rtr_ph = 0;
    rtr_mode = 1;
    for (int i = 0; i < 16; i++) send(i == 0, i == 15, 8, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t3_blk_cnt", 64'(blk_cnt_o), 64'd2);
    chk("t3_proto_err", 64'(proto_err_o), 64'd0);

    // Test 6: reset with two beats buffered.
    do_reset();
    rtr_mode = 3;
    @(posedge clk);
    #1;
    send(1, 0, 8, 1'b0, 1'b0, 1'b0);
    send(0, 0, 8, 1'b0, 1'b0, 1'b0);
    chk("t6_full_rtr_o", 64'(rtr_o), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("t6_rts_o", 64'(rts_o), 64'd0);
    chk_data("t6_data_o", data_o, '0);
    chk("t6_blk_cnt", 64'(blk_cnt_o), 64'd0);
    chk("t6_proto_err", 64'(proto_err_o), 64'd0);
    chk("t6_state", 64'(dbg_state), 64'(IDLE));
    rtr_mode = 0;
    @(posedge clk);
    #1;
    send(1, 1, 4, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t6_blk_after", 64'(blk_cnt_o), 64'd1);
    chk("t6_err_after", 64'(proto_err_o), 64'd0);

    // Randomized streams against the reference model.
    do_reset();
    rtr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      rs = m_in_stream ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      re = ($urandom_range(0, 7) == 0);
      send(rs, re, $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      rtr_mode = 2;
    end
    drain();
    chk("rnd_blk_cnt", 64'(blk_cnt_o), 64'(exp_blk));
    chk("rnd_proto_err", 64'(proto_err_o), 64'(m_err));
    chk("rnd_state", 64'(dbg_state), 64'(m_in_stream));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
